// File: rtl/sys_spm_fill_checker.sv
// Scratchpad fill/check initiator: writes seed+i over a contiguous word range and,
// when enabled, reads the range back and counts mismatches against the same pattern.
module sys_spm_fill_checker #(
    parameter int AddrWidth      = 20,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [AddrWidth-1:0]   num_words_i,
    input  logic [DataWidth-1:0]   seed_i,
    input  logic                   check_en_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [15:0]            err_count_o,
    output logic [AddrWidth-1:0]   first_err_addr_o,
    output logic                   req_o,
    input  logic                   gnt_i,
    output logic [AddrWidth-1:0]   addr_o,
    output logic                   we_o,
    output logic [DataWidth-1:0]   wdata_o,
    output logic [DataWidth/8-1:0] be_o,
    input  logic                   rvalid_i,
    input  logic [DataWidth-1:0]   rdata_i
);

    localparam int                   ByteCount = DataWidth / 8;
    localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(ByteCount);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(ByteCount - 1);
    localparam logic [3:0]           OutMax    = 4'(MaxOutstanding);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWrite = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StDrain = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [AddrWidth-1:0] base_q;
    logic [AddrWidth-1:0] last_q;
    logic [AddrWidth-1:0] issue_idx_q;
    logic                 check_q;
    logic [3:0]           out_q, out_d;
    logic [AddrWidth-1:0] resp_addr_q;
    logic [DataWidth-1:0] resp_data_q;

    logic [AddrWidth-1:0] start_base;
    logic                 start_acc;
    logic                 xfer;
    logic                 rd_gnt;
    logic                 rsp_acc;
    logic                 issue_last;
    logic                 mismatch;

    assign start_base = base_addr_i & AlignMask;
    assign start_acc  = (state_q == StIdle) && start_i;
    assign xfer       = req_o && gnt_i;
    assign rd_gnt     = xfer && !we_o;
    // Responses with nothing outstanding are stray and must not touch the checker.
    assign rsp_acc    = rvalid_i && (out_q != 4'd0);
    assign issue_last = (issue_idx_q == last_q);
    assign mismatch   = rsp_acc && (rdata_i != resp_data_q);
    assign be_o       = '1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        out_d = out_q;
        if (rd_gnt && !rsp_acc) begin
            out_d = out_q + 4'd1;
        end else if (!rd_gnt && rsp_acc) begin
            out_d = out_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_i) state_d = (num_words_i == '0) ? StDone : StWrite;
            StWrite: if (xfer && issue_last) state_d = check_q ? StRead : StDone;
            StRead:  if (xfer && issue_last) state_d = StDrain;
            StDrain: if (out_d == 4'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others.
        if (rst_i) begin
            state_q          <= StIdle;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            out_q            <= 4'd0;
            base_q           <= '0;
            last_q           <= '0;
            issue_idx_q      <= '0;
            check_q          <= 1'b0;
            req_o            <= 1'b0;
            we_o             <= 1'b0;
            addr_o           <= '0;
            wdata_o          <= '0;
            resp_addr_q      <= '0;
            resp_data_q      <= '0;
            error_o          <= 1'b0;
            err_count_o      <= 16'd0;
            first_err_addr_o <= '0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != StIdle);
            done_o  <= (state_d == StDone);
            out_q   <= out_d;

            if (start_acc) begin
                base_q           <= start_base;
                last_q           <= num_words_i - AddrWidth'(1);
                check_q          <= check_en_i;
                issue_idx_q      <= '0;
                addr_o           <= start_base;
                wdata_o          <= seed_i;
                we_o             <= 1'b1;
                req_o            <= (num_words_i != '0);
                resp_addr_q      <= start_base;
                resp_data_q      <= seed_i;
                error_o          <= 1'b0;
                err_count_o      <= 16'd0;
                first_err_addr_o <= '0;
            end else if (xfer) begin
                if (issue_last) begin
                    // The first read is presented right behind the last write: no bubble.
                    issue_idx_q <= '0;
                    if (we_o && check_q) begin
                        addr_o <= base_q;
                        we_o   <= 1'b0;
                        req_o  <= 1'b1;
                    end else begin
                        req_o <= 1'b0;
                    end
                end else begin
                    issue_idx_q <= issue_idx_q + AddrWidth'(1);
                    addr_o      <= addr_o + AddrStep;
                    if (we_o) wdata_o <= wdata_o + DataWidth'(1);
                    req_o <= we_o || (out_d != OutMax);
                end
            end else if ((state_q == StRead) && !req_o) begin
                req_o <= (out_d != OutMax);
            end

            if (rsp_acc) begin
                resp_addr_q <= resp_addr_q + AddrStep;
                resp_data_q <= resp_data_q + DataWidth'(1);
                if (mismatch) begin
                    error_o <= 1'b1;
                    if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
                    if (err_count_o == 16'd0) first_err_addr_o <= resp_addr_q;
                end
            end
        end
    end

endmodule
